// File: rtl/regfile_wr_arbiter_if.sv
// Purpose : bundles the requester handshake and the registered regfile write port of the arbiter.
// Latency : n/a (signal bundle only).
// Backpres: req_ready/wr_stall carry the flow control; see regfile_wr_arbiter.
//
// Signals:
//   req_valid/req_ready   per-requester valid/ready, transfer = valid[i] & ready[i]
//   req_addr/req_data     requester i fields at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   wr_stall              regfile cannot consume the current write
//   wr_en/wr_sel/wr_data  registered write stage feeding the enable decoder and regfile
//   grant_id              requester whose write currently sits in the stage
// Modports: master = the arbiter, slave = requesters plus regfile.
interface regfile_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   wr_stall;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_sel;
    logic [DATA_W-1:0]      wr_data;
    logic [IDW-1:0]         grant_id;

    modport master (
        input  req_valid, req_addr, req_data, wr_stall,
        output req_ready, wr_en, wr_sel, wr_data, grant_id
    );

    modport slave (
        output req_valid, req_addr, req_data, wr_stall,
        input  req_ready, wr_en, wr_sel, wr_data, grant_id
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose : round-robin arbiter sharing the single regfile write port among NREQ requesters.
// Latency : a transfer in cycle t appears on wr_en/wr_sel/wr_data at t+1; 1 write/cycle sustained.
// Backpres: wr_stall holds a full stage and forces req_ready to 0; ignored while the stage is empty.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset; discards any write held in the stage
//   bus    regfile_wr_arbiter_if.master (requester handshake in, registered write port out)
module regfile_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wr_arbiter_if.master  bus
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0]   NREQ_L = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_L = IDW'(NREQ - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDW-1:0]      ptr_q;
    logic [ADDR_W-1:0]   wr_sel_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [IDW-1:0]      grant_q;

    logic                accept;
    logic                found;
    logic [IDW-1:0]      off;
    logic [IDW-1:0]      win;
    logic [IDW:0]        sum;
    logic [2*NREQ-1:0]   dbl;
    logic [NREQ-1:0]     rot;
    logic [ADDR_W-1:0]   wr_sel_d;
    logic [DATA_W-1:0]   wr_data_d;
    logic [IDW-1:0]      ptr_d;

    // Stage can take a new write when empty, or when its current write leaves this cycle.
    assign accept = (state_q == EMPTY) || !bus.wr_stall;

    // Rotate the valid vector so that index ptr lands at bit 0; the first set bit
    // of the rotated vector is then the round-robin winner's offset from ptr.
    assign dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
    end

    // ptr + offset, wrapped modulo NREQ (NREQ need not be a power of two).
    assign sum = {1'b0, ptr_q} + {1'b0, off};
    assign win = (sum >= NREQ_L) ? IDW'(sum - NREQ_L) : sum[IDW-1:0];

    always_comb begin
        wr_sel_d  = '0;
        wr_data_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                wr_sel_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
                wr_data_d = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_d = (win == LAST_L) ? '0 : win + 1'b1;

    // Ready depends only on valid, ptr and stage state: never on addr/data.
    always_comb begin
        bus.req_ready = '0;
        if (found && accept) begin
            bus.req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            ptr_q     <= '0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            grant_q   <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (found) begin
                        state_q   <= FULL;
                        wr_sel_q  <= wr_sel_d;
                        wr_data_q <= wr_data_d;
                        grant_q   <= win;
                        ptr_q     <= ptr_d;
                    end
                end
                FULL: begin
                    // Stalled: everything holds. Otherwise the current write drains
                    // and the next winner (if any) slides in without a bubble.
                    if (!bus.wr_stall) begin
                        if (found) begin
                            wr_sel_q  <= wr_sel_d;
                            wr_data_q <= wr_data_d;
                            grant_q   <= win;
                            ptr_q     <= ptr_d;
                        end else begin
                            state_q <= EMPTY;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.wr_en    = (state_q == FULL);
    assign bus.wr_sel   = wr_sel_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.grant_id = grant_q;
endmodule
